// File: rtl/csr_file_ext.sv
// CSR register file: RW/RS/RC (+ immediate forms) access, free-running cycle and
// retired-instruction counters, trap capture of EPC/CAUSE, and an async active-high reset.
module csr_file_ext #(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int CYCLE_IDX   = 3,
  parameter int INSTRET_IDX = 4,
  parameter int EPC_IDX     = 5,
  parameter int CAUSE_IDX   = 6,
  parameter int TVEC_IDX    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_func,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [4:0]      csr_zimm,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] epc_out,
  output logic [XLEN-1:0] tvec_out
);
  localparam int IW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     w_ent [NUM_REGS];
  logic [IW-1:0]       w_idx;
  logic                w_in_range;
  logic [XLEN-1:0]     w_old;
  logic [XLEN-1:0]     w_op;
  logic [XLEN-1:0]     w_new;
  logic                w_writes;
  logic                w_ro_target;
  logic                w_commit;
  logic [NUM_REGS-1:0] w_wr_sel;

  assign w_idx      = csr_addr[IW-1:0];
  assign w_in_range = (csr_addr >> IW) == 12'd0;
  assign w_old      = (w_in_range && w_idx != '0) ? w_ent[w_idx] : '0;
  assign csr_rdata  = w_old;
  assign w_op       = csr_func[2] ? XLEN'(csr_zimm) : csr_wdata;

  always_comb begin
    w_new = w_old;
    case (csr_func[1:0])
      2'b01:   w_new = w_op;
      2'b10:   w_new = w_old | w_op;
      2'b11:   w_new = w_old & ~w_op;
      default: w_new = w_old;
    endcase
  end

  // Set/clear with a zero operand is a pure read and never counts as a write.
  assign w_writes    = (csr_func[1:0] == 2'b01) || (w_op != '0);
  assign w_ro_target = (w_idx == IW'(CYCLE_IDX)) || (w_idx == IW'(INSTRET_IDX)) ||
                       (csr_addr[11:10] == 2'b11);
  assign csr_illegal = csr_valid &&
                       (!w_in_range || csr_func[1:0] == 2'b00 || (w_writes && w_ro_target));
  assign w_commit    = csr_valid && !csr_illegal && !trap_valid && w_writes && w_idx != '0;
  assign w_wr_sel    = w_commit ? (NUM_REGS'(1) << w_idx) : '0;

  assign w_ent[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_ent
    logic [XLEN-1:0] r_q;
    if (g == CYCLE_IDX) begin : g_cyc
      always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '0;
        else     r_q <= r_q + XLEN'(1);
    end else if (g == INSTRET_IDX) begin : g_ret
      always_ff @(posedge clk or posedge rst)
        if (rst)         r_q <= '0;
        else if (retire) r_q <= r_q + XLEN'(1);
    end else if (g == EPC_IDX || g == CAUSE_IDX) begin : g_trap
      // Trap capture overrides any CSR write in the same cycle.
      always_ff @(posedge clk or posedge rst)
        if (rst)             r_q <= '0;
        else if (trap_valid) r_q <= (g == EPC_IDX) ? trap_epc : trap_cause;
        else if (w_wr_sel[g]) r_q <= w_new;
    end else begin : g_gen
      always_ff @(posedge clk or posedge rst)
        if (rst)              r_q <= '0;
        else if (w_wr_sel[g]) r_q <= w_new;
    end
    assign w_ent[g] = r_q;
  end

  assign epc_out  = w_ent[EPC_IDX];
  assign tvec_out = w_ent[TVEC_IDX];
endmodule

// File: tb/tb_csr_file_ext.sv
// Directed bench for csr_file_ext: default 32-bit instance plus an XLEN=8 instance for counter wrap.
module tb_csr_file_ext;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [2:0]  csr_func = '0;
  logic [31:0] csr_wdata = '0;
  logic [4:0]  csr_zimm = '0;
  logic        retire = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_epc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] csr_rdata, epc_out, tvec_out;
  logic        csr_illegal;

  logic        rst8 = 1'b1;
  logic [7:0]  rdata8, epc8, tvec8;
  logic        ill8;

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;

  always #5 clk = ~clk;

  csr_file_ext dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_func(csr_func),
    .csr_wdata(csr_wdata), .csr_zimm(csr_zimm), .retire(retire), .trap_valid(trap_valid),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .epc_out(epc_out), .tvec_out(tvec_out)
  );

  csr_file_ext #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst8), .csr_valid(1'b0), .csr_addr(12'h003), .csr_func(3'b001),
    .csr_wdata(8'h00), .csr_zimm(5'd0), .retire(1'b0), .trap_valid(1'b0),
    .trap_epc(8'h00), .trap_cause(8'h00), .csr_rdata(rdata8),
    .csr_illegal(ill8), .epc_out(epc8), .tvec_out(tvec8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [2:0] f,
                       input logic [31:0] wd, input logic [4:0] zi);
    csr_valid = v; csr_addr = a; csr_func = f; csr_wdata = wd; csr_zimm = zi;
    #1;
  endtask

  initial begin
    // Reset state, held across a clock edge
    drive(1'b0, 12'h003, 3'b001, 32'h0, 5'd0);
    chk("rst_cycle", csr_rdata, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_tvec", tvec_out, 32'h0);
    tick();
    chk("rst_hold_cycle", csr_rdata, 32'h0);
    rst = 1'b0;
    ncyc = 0;
    #1;
    chk("cycle_start", csr_rdata, 32'h0);

    // RW then RS on TVEC
    tick();
    drive(1'b1, 12'h007, 3'b001, 32'h0000_1000, 5'd0);
    chk("rw_tvec_ill", {31'b0, csr_illegal}, 32'h0);
    chk("rw_tvec_rd", csr_rdata, 32'h0);
    tick();
    chk("tvec_after_rw", tvec_out, 32'h0000_1000);
    drive(1'b1, 12'h007, 3'b010, 32'h0000_000F, 5'd0);
    chk("rs_tvec_rd", csr_rdata, 32'h0000_1000);
    tick();
    chk("tvec_after_rs", tvec_out, 32'h0000_100F);

    // RC on TVEC clears the low nibble again
    drive(1'b1, 12'h007, 3'b011, 32'h0000_000F, 5'd0);
    tick();
    chk("tvec_after_rc", tvec_out, 32'h0000_1000);

    // RCI zimm=0 to CYCLE is a legal pure read; RW to CYCLE is illegal
    drive(1'b1, 12'h003, 3'b111, 32'h0, 5'd0);
    chk("rci0_cyc_ill", {31'b0, csr_illegal}, 32'h0);
    chk("rci0_cyc_rd", csr_rdata, ncyc);
    tick();
    drive(1'b1, 12'h003, 3'b001, 32'h55, 5'd0);
    chk("rw_cyc_ill", {31'b0, csr_illegal}, 32'h1);
    chk("rw_cyc_rd", csr_rdata, ncyc);
    tick();
    drive(1'b0, 12'h003, 3'b001, 32'h0, 5'd0);
    chk("cyc_unaffected", csr_rdata, ncyc);

    // Trap wins over a simultaneous RW to EPC
    trap_valid = 1'b1; trap_epc = 32'h80; trap_cause = 32'h2;
    drive(1'b1, 12'h005, 3'b001, 32'h44, 5'd0);
    chk("trap_rw_ill", {31'b0, csr_illegal}, 32'h0);
    tick();
    trap_valid = 1'b0;
    drive(1'b0, 12'h006, 3'b001, 32'h0, 5'd0);
    chk("trap_epc_out", epc_out, 32'h80);
    chk("trap_cause", csr_rdata, 32'h2);

    // RWI to EPC with the immediate operand
    drive(1'b1, 12'h005, 3'b101, 32'hFFFF_FFFF, 5'h1F);
    chk("rwi_epc_rd", csr_rdata, 32'h80);
    tick();
    chk("rwi_epc_out", epc_out, 32'h1F);

    // Out-of-range address, including one aliasing TVEC
    drive(1'b1, 12'h020, 3'b001, 32'h1234, 5'd0);
    chk("oor_ill", {31'b0, csr_illegal}, 32'h1);
    chk("oor_rd", csr_rdata, 32'h0);
    drive(1'b1, 12'h027, 3'b001, 32'hFFFF, 5'd0);
    chk("oor_alias_ill", {31'b0, csr_illegal}, 32'h1);
    tick();
    chk("oor_alias_nowr", tvec_out, 32'h0000_1000);

    // Reserved funct3 and read-only address space
    drive(1'b1, 12'h007, 3'b000, 32'h0, 5'd0);
    chk("func000_ill", {31'b0, csr_illegal}, 32'h1);
    drive(1'b1, 12'h007, 3'b100, 32'h0, 5'd0);
    chk("func100_ill", {31'b0, csr_illegal}, 32'h1);
    drive(1'b1, 12'hC07, 3'b010, 32'h1, 5'd0);
    chk("ro_space_ill", {31'b0, csr_illegal}, 32'h1);
    drive(1'b0, 12'h020, 3'b001, 32'h0, 5'd0);
    chk("novalid_ill", {31'b0, csr_illegal}, 32'h0);

    // Index 0 stays zero
    drive(1'b1, 12'h000, 3'b001, 32'hDEAD, 5'd0);
    chk("idx0_ill", {31'b0, csr_illegal}, 32'h0);
    tick();
    drive(1'b0, 12'h000, 3'b001, 32'h0, 5'd0);
    chk("idx0_rd", csr_rdata, 32'h0);

    // Ten retires
    retire = 1'b1;
    repeat (10) tick();
    retire = 1'b0;
    drive(1'b0, 12'h004, 3'b001, 32'h0, 5'd0);
    chk("instret10", csr_rdata, 32'd10);

    // Reset pulse between edges clears everything immediately
    rst = 1'b1;
    #1;
    chk("rst_instret", csr_rdata, 32'h0);
    chk("rst_epc_mid", epc_out, 32'h0);
    chk("rst_tvec_mid", tvec_out, 32'h0);
    drive(1'b1, 12'h003, 3'b001, 32'h1, 5'd0);
    chk("rst_cycle_mid", csr_rdata, 32'h0);
    chk("rst_ill_comb", {31'b0, csr_illegal}, 32'h1);
    rst = 1'b0;
    ncyc = 0;
    drive(1'b0, 12'h003, 3'b001, 32'h0, 5'd0);
    tick();
    chk("cycle_after_rst", csr_rdata, 32'd1);

    // XLEN=8 counter wrap
    @(negedge clk);
    rst8 = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    chk("wrap_fe", {24'b0, rdata8}, 32'hFE);
    @(posedge clk); #1;
    chk("wrap_ff", {24'b0, rdata8}, 32'hFF);
    @(posedge clk); #1;
    chk("wrap_00", {24'b0, rdata8}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_file_ext.md
CSR_FILE_EXT -- requirements
Module: csr_file_ext

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every CSR and data port.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of CSR entries (power of two, 8..256).
REQ-003 SHALL have parameters CYCLE_IDX=3, INSTRET_IDX=4, EPC_IDX=5, CAUSE_IDX=6, TVEC_IDX=7, entry indices of the special CSRs (distinct, nonzero, < NUM_REGS).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port csr_valid  input  1  CSR instruction present this cycle.
REQ-007 SHALL have port csr_addr  input  12  CSR address.
REQ-008 SHALL have port csr_func  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-009 SHALL have port csr_wdata  input  XLEN  rs1 operand (register forms).
REQ-010 SHALL have port csr_zimm  input  5  immediate operand (I forms), zero-extended to XLEN.
REQ-011 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-012 SHALL have port trap_valid  input  1  trap entry request.
REQ-013 SHALL have port trap_epc / trap_cause  input  XLEN each  values captured on trap.
REQ-014 SHALL have port csr_rdata  output  XLEN  pre-write value of the addressed CSR.
REQ-015 SHALL have port csr_illegal  output  1  access rejected this cycle.
REQ-016 SHALL have ports epc_out / tvec_out  output  XLEN each  current EPC and TVEC entries.

Function
REQ-017 SHALL map csr_addr to entry index csr_addr[log2(NUM_REGS)-1:0]; address is in range only when all higher address bits are zero.
REQ-018 SHALL drive csr_rdata combinationally with the addressed entry's current value (read-before-write); index 0 and out-of-range read as 0.
REQ-019 SHALL compute operand op = csr_wdata for func[2]=0, else zero-extended csr_zimm.
REQ-020 SHALL compute new value: RW/RWI -> op; RS/RSI -> old | op; RC/RCI -> old & ~op.
REQ-021 SHALL commit the new value on the rising clk edge when csr_valid=1, not illegal, trap_valid=0, index != 0.
REQ-022 SHALL suppress the write for RS/RC/RSI/RCI when op = 0 (pure read, no side effects).
REQ-023 SHALL assert csr_illegal combinationally when csr_valid=1 and: address out of range, func in {000,100}, or a write (per REQ-022) targets CYCLE_IDX or INSTRET_IDX or csr_addr[11:10]=11.
REQ-024 SHALL hold csr_illegal=0 when csr_valid=0; illegal accesses SHALL not modify any entry but SHALL still return csr_rdata.
REQ-025 SHALL increment entry CYCLE_IDX by 1 every rising clk edge when not in reset, wrapping 2^XLEN-1 -> 0.
REQ-026 SHALL increment entry INSTRET_IDX by 1 on each rising edge with retire=1, same wrap rule.
REQ-027 SHALL, on a rising edge with trap_valid=1, write trap_epc to EPC_IDX and trap_cause to CAUSE_IDX, and SHALL discard any same-cycle CSR write (trap wins; csr_rdata still valid).
REQ-028 SHALL keep entry 0 permanently zero.
REQ-029 SHALL drive epc_out and tvec_out from the entries' registered values (new value visible the cycle after write).
REQ-030 SHALL treat a same-cycle CSR write and counter increment as impossible (counters read-only); counters increment unconditionally of csr_valid.

Reset
REQ-031 SHALL clear every entry, including counters, to 0 immediately on rst=1, independent of clk.
REQ-032 SHALL hold all entries at 0 while rst=1; first counter increment occurs on the first rising edge after rst deasserts.
REQ-033 SHALL abort any in-flight write when rst asserts mid-cycle; outputs csr_rdata=0, epc_out=0, tvec_out=0 during reset; csr_illegal follows REQ-023 combinationally.

Verification
REQ-034 SHALL cover: RW to TVEC_IDX with 0x0000_1000, then RS with 0x0F -> rdata of RS = 0x0000_1000, tvec_out = 0x0000_100F next cycle.
REQ-035 SHALL cover: RCI zimm=0 to CYCLE_IDX -> no illegal, returns cycle count; RW to CYCLE_IDX -> csr_illegal=1, counter unaffected.
REQ-036 SHALL cover: CYCLE forced near wrap via 2^XLEN-2 cycles (XLEN=8 build) -> reads 0xFE, 0xFF, 0x00 on consecutive cycles.
REQ-037 SHALL cover: trap_valid=1 with epc=0x80, cause=0x2 and simultaneous RW to EPC_IDX of 0x44 -> epc_out=0x80, cause entry=0x2.
REQ-038 SHALL cover: csr_addr=0x020 (NUM_REGS=32) -> csr_illegal=1, rdata=0; write to index 0 -> reads 0 afterwards.
REQ-039 SHALL cover: rst pulse between clock edges after writes and 10 retires -> all entries, INSTRET, epc_out read 0 immediately.
